// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared sideband types and exp2 LUT constants/generator
package types_pkg;

    typedef struct packed {
        logic [3:0] chan;
        logic [7:0] seq;
    } flags_t;

    typedef struct packed {
        logic   valid;
        logic   zero;
        flags_t flags;
    } exp2_meta_t;

    localparam int    EXP2_FRAC_WIDTH = 10;
    localparam string EXP2_LUT_FILE   = "exp2_lut.mem";

    // Floor square root of a 128-bit integer, bit by bit from the MSB.
    function automatic logic [63:0] exp2_isqrt(input logic [127:0] n);
        logic [63:0]  r;
        logic [127:0] t;
        r = '0;
        for (int b = 63; b >= 0; b--) begin
            t = {64'd0, r | (64'd1 << b)};
            if (t * t <= n) begin
                r = r | (64'd1 << b);
            end
        end
        return r;
    endfunction

    // roots[k] = 2^(2^k / 2^fw) in Q1.62, built by repeated square roots of sqrt(2).
    function automatic logic [15:0][63:0] exp2_roots(input int fw);
        logic [15:0][63:0] r;
        r = '0;
        r[fw-1] = exp2_isqrt(128'd2 << 124);
        for (int k = fw - 2; k >= 0; k--) begin
            r[k] = exp2_isqrt({64'd0, r[k+1]} << 62);
        end
        return r;
    endfunction

    // round(2^(f/2^fw) * 2^(dw-1)); the product of roots selected by the bits of f.
    function automatic logic [127:0] exp2_lut_entry(input int f, input int fw, input int dw,
                                                    input logic [15:0][63:0] roots);
        logic [127:0] acc;
        acc = 128'd1 << 62;
        for (int k = 0; k < fw; k++) begin
            if (((f >> k) & 1) != 0) begin
                acc = (acc * {64'd0, roots[k]}) >> 62;
            end
        end
        acc = (acc + (128'd1 << (62 - dw))) >> (63 - dw);
        return acc;
    endfunction

endpackage

// File: rtl/exp2_lut.sv
// rtl/exp2_lut.sv - synchronous-read ROM of 2^frac mantissas in Q1.(DATA_WIDTH-1)
module exp2_lut
    import types_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_WIDTH = EXP2_FRAC_WIDTH
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [FRAC_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data
);

    localparam int DEPTH = 2 ** FRAC_WIDTH;
    localparam logic [15:0][63:0] ROOTS = exp2_roots(FRAC_WIDTH);

    logic [DATA_WIDTH-1:0] rom [DEPTH];

    // Contents are fixed at elaboration so the ROM maps to constant storage.
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam logic [DATA_WIDTH-1:0] ENTRY =
            DATA_WIDTH'(exp2_lut_entry(i, FRAC_WIDTH, DATA_WIDTH, ROOTS));
        assign rom[i] = ENTRY;
    end

    always_ff @(posedge clk) begin
        if (en) begin
            data <= rom[addr];
        end
    end

endmodule

// File: rtl/exp2_lin_approx.sv
// rtl/exp2_lin_approx.sv - log2 to linear magnitude-squared converter, 3-stage pipe
module exp2_lin_approx
    import types_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_WIDTH = EXP2_FRAC_WIDTH,
    parameter int OUT_WIDTH  = 2 * DATA_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  logic [DATA_WIDTH-1:0] log_in,
    input  flags_t                flags_in,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic [OUT_WIDTH-1:0]  lin_out,
    output flags_t                flags_out
);

    localparam int IP_WIDTH   = DATA_WIDTH - FRAC_WIDTH;
    localparam int WIDE_WIDTH = DATA_WIDTH + OUT_WIDTH;

    logic                  en;
    exp2_meta_t            meta1;
    exp2_meta_t            meta2;
    logic [IP_WIDTH-1:0]   ip1;
    logic [DATA_WIDTH-1:0] mant1;
    logic [OUT_WIDTH-1:0]  lin2;
    logic [WIDE_WIDTH-1:0] wide;
    logic [OUT_WIDTH:0]    shifted;
    logic [OUT_WIDTH-1:0]  lin_s2;

    // The whole pipe moves as one; it only stalls when the output register is full and blocked.
    assign en       = ready_out | ~valid_out;
    assign ready_in = en;

    exp2_lut #(
        .DATA_WIDTH(DATA_WIDTH),
        .FRAC_WIDTH(FRAC_WIDTH)
    ) u_lut (
        .clk (clk),
        .en  (en),
        .addr(log_in[FRAC_WIDTH-1:0]),
        .data(mant1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            meta1 <= '0;
            ip1   <= '0;
        end else if (en) begin
            meta1 <= '{valid: valid_in, zero: (log_in == '0), flags: flags_in};
            ip1   <= log_in[DATA_WIDTH-1:FRAC_WIDTH];
        end
    end

    always_comb begin
        wide    = {{OUT_WIDTH{1'b0}}, mant1} << ip1;
        shifted = (OUT_WIDTH + 1)'(wide >> (DATA_WIDTH - 1));
        if ((int'(ip1) >= OUT_WIDTH) || shifted[OUT_WIDTH]) begin
            lin_s2 = '1;
        end else begin
            lin_s2 = shifted[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta2 <= '0;
            lin2  <= '0;
        end else if (en) begin
            meta2 <= meta1;
            lin2  <= lin_s2;
        end
    end

    // A log value of 0 stands for zero magnitude, not 2^0.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            lin_out   <= '0;
            flags_out <= '0;
        end else if (en) begin
            valid_out <= meta2.valid;
            lin_out   <= meta2.zero ? '0 : lin2;
            flags_out <= meta2.flags;
        end
    end

endmodule

// File: tb/tb_exp2_lin_approx.sv
// tb/tb_exp2_lin_approx.sv - self-checking bench for exp2_lin_approx
module tb_exp2_lin_approx;
    import types_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        ready_in;
    logic [15:0] log_in;
    flags_t      flags_in;
    logic        valid_out;
    logic        ready_out;
    logic [32:0] lin_out;
    flags_t      flags_out;

    typedef struct {
        logic [32:0] lin;
        flags_t      flags;
    } res_t;

    res_t        exp_q[$];
    res_t        got_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        in_hs, out_hs;
    logic        s_valid_out;
    logic [32:0] s_lin;
    flags_t      s_flags;

    exp2_lin_approx dut (
        .clk      (clk),
        .reset    (reset),
        .valid_in (valid_in),
        .ready_in (ready_in),
        .log_in   (log_in),
        .flags_in (flags_in),
        .valid_out(valid_out),
        .ready_out(ready_out),
        .lin_out  (lin_out),
        .flags_out(flags_out)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] model(input logic [15:0] l);
        int          ip;
        int          f;
        logic [63:0] mant;
        logic [63:0] w;
        if (l == 16'd0) return 33'd0;
        ip = int'(l[15:10]);
        f  = int'(l[9:0]);
        if (ip >= 33) return '1;
        mant = 64'($rtoi($pow(2.0, real'(f) / 1024.0) * 32768.0 + 0.5));
        w = (mant << ip) >> 15;
        if (w > 64'h1_FFFF_FFFF) return '1;
        return w[32:0];
    endfunction

    // Called just after a negedge; samples 1 time unit before the next posedge.
    task automatic tick();
        #4;
        s_valid_out = valid_out;
        s_lin       = lin_out;
        s_flags     = flags_out;
        in_hs       = valid_in && ready_in && !reset;
        out_hs      = valid_out && ready_out && !reset;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (in_hs)  exp_q.push_back('{lin: model(log_in), flags: flags_in});
            if (out_hs) got_q.push_back('{lin: lin_out, flags: flags_out});
        end
        @(negedge clk);
    endtask

    task automatic send_one(input logic [15:0] l, input logic [7:0] tag,
                            output logic [32:0] lin, output int lat);
        exp_q.delete();
        got_q.delete();
        valid_in  = 1'b1;
        log_in    = l;
        flags_in  = '{chan: 4'h0, seq: tag};
        ready_out = 1'b1;
        tick();
        valid_in = 1'b0;
        lat = 0;
        lin = 'x;
        for (int i = 0; i < 20 && got_q.size() == 0; i++) begin
            tick();
            lat++;
        end
        if (got_q.size() > 0) lin = got_q.pop_front().lin;
        else lat = -1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        valid_in  = 1'b1;
        log_in    = 16'h0400;
        flags_in  = '{chan: 4'h3, seq: 8'h55};
        ready_out = 1'b1;
        repeat (2) tick();
        reset    = 1'b0;
        valid_in = 1'b0;
        tick();
        n_checks++;
        if (s_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid_out got %0b want 0", s_valid_out);
        end
        n_checks++;
        if (s_lin !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_lin_out got %h want 0", s_lin);
        end
        n_checks++;
        if (s_flags !== '0) begin
            n_fail++;
            $display("FAIL reset_flags_out got %h want 0", s_flags);
        end
    endtask

    task automatic test_exact_powers();
        logic [32:0] lin;
        int          lat;
        send_one(16'h0400, 8'd1, lin, lat);
        n_checks++;
        if (lin !== 33'd2) begin
            n_fail++;
            $display("FAIL pow_1p0 got %h want 2", lin);
        end
        n_checks++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL latency_1p0 got %0d want 3", lat);
        end
        send_one(16'h2000, 8'd2, lin, lat);
        n_checks++;
        if (lin !== 33'd256) begin
            n_fail++;
            $display("FAIL pow_8p0 got %h want 256", lin);
        end
        n_checks++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL latency_8p0 got %0d want 3", lat);
        end
    endtask

    task automatic test_fraction();
        logic [32:0] lin;
        int          lat;
        send_one(16'h0A00, 8'd3, lin, lat);
        n_checks++;
        if (lin !== 33'd5) begin
            n_fail++;
            $display("FAIL frac_2p5 got %h want 5", lin);
        end
        send_one(16'h0000, 8'd4, lin, lat);
        n_checks++;
        if (lin !== 33'd0) begin
            n_fail++;
            $display("FAIL log_zero got %h want 0", lin);
        end
    endtask

    task automatic test_saturation();
        logic [32:0] lin;
        int          lat;
        send_one(16'h8400, 8'd5, lin, lat);
        n_checks++;
        if (lin !== 33'h1_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL sat_ip33 got %h want 1ffffffff", lin);
        end
        send_one(16'h8000, 8'd6, lin, lat);
        n_checks++;
        if (lin !== 33'h1_0000_0000) begin
            n_fail++;
            $display("FAIL ip32_exact got %h want 100000000", lin);
        end
    endtask

    task automatic test_back_to_back();
        int   accepted = 0;
        res_t e, g;
        exp_q.delete();
        got_q.delete();
        ready_out = 1'b1;
        for (int i = 0; i < 20; i++) begin
            valid_in = 1'b1;
            log_in   = 16'($urandom_range(16'h0001, 16'h87FF));
            flags_in = '{chan: 4'hA, seq: 8'(i)};
            tick();
            if (in_hs) accepted++;
        end
        valid_in = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (accepted !== 20 || got_q.size() !== 20) begin
            n_fail++;
            $display("FAIL b2b_rate accepted %0d outputs %0d want 20 20", accepted, got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g.lin !== e.lin || g.flags !== e.flags) begin
                n_fail++;
                $display("FAIL b2b_data got %h/%h want %h/%h", g.lin, g.flags, e.lin, e.flags);
            end
        end
    endtask

    task automatic test_backpressure();
        int          sent = 0;
        int          cyc  = 0;
        logic [15:0] cur;
        logic        prev_stall = 1'b0;
        logic [32:0] prev_lin;
        flags_t      prev_flags;
        res_t        e, g;
        exp_q.delete();
        got_q.delete();
        cur = 16'($urandom_range(0, 16'h8BFF));
        while ((sent < 100 || got_q.size() < 100) && cyc < 3000) begin
            valid_in  = (sent < 100) && ($urandom_range(0, 3) != 0);
            log_in    = cur;
            flags_in  = '{chan: 4'(sent), seq: 8'(sent)};
            ready_out = ($urandom_range(0, 2) != 0);
            tick();
            if (prev_stall) begin
                n_checks++;
                if (s_valid_out !== 1'b1 || s_lin !== prev_lin || s_flags !== prev_flags) begin
                    n_fail++;
                    $display("FAIL stall_hold got %0b/%h/%h want 1/%h/%h",
                             s_valid_out, s_lin, s_flags, prev_lin, prev_flags);
                end
            end
            prev_stall = s_valid_out && !ready_out;
            prev_lin   = s_lin;
            prev_flags = s_flags;
            if (in_hs) begin
                sent++;
                cur = ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'($urandom_range(0, 16'h8BFF));
            end
            cyc++;
        end
        valid_in = 1'b0;
        n_checks++;
        if (got_q.size() !== 100 || exp_q.size() !== 100) begin
            n_fail++;
            $display("FAIL bp_count got %0d outputs %0d expected want 100 100",
                     got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g.lin !== e.lin || g.flags !== e.flags) begin
                n_fail++;
                $display("FAIL bp_data got %h/%h want %h/%h", g.lin, g.flags, e.lin, e.flags);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic        any_valid = 1'b0;
        logic [32:0] lin;
        int          lat;
        exp_q.delete();
        got_q.delete();
        ready_out = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1;
            log_in   = 16'h0400 + 16'(i) * 16'h0100;
            flags_in = '{chan: 4'h7, seq: 8'(i)};
            tick();
        end
        valid_in = 1'b0;
        reset    = 1'b1;
        tick();
        reset     = 1'b0;
        ready_out = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (s_valid_out) any_valid = 1'b1;
        end
        n_checks++;
        if (any_valid !== 1'b0 || got_q.size() !== 0) begin
            n_fail++;
            $display("FAIL midreset_flush valid_seen %0b outputs %0d want 0 0", any_valid, got_q.size());
        end
        send_one(16'h1800, 8'd9, lin, lat);
        n_checks++;
        if (lin !== 33'd64) begin
            n_fail++;
            $display("FAIL midreset_value got %h want 64", lin);
        end
        n_checks++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL midreset_latency got %0d want 3", lat);
        end
    endtask

    initial begin
        reset     = 1'b1;
        valid_in  = 1'b0;
        log_in    = '0;
        flags_in  = '0;
        ready_out = 1'b1;
        @(negedge clk);
        test_reset();
        test_exact_powers();
        test_fraction();
        test_saturation();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
